// File: rtl/mem_access_unit.sv
// mem_access_unit: CPU load/store front end for a byte-addressed, word-wide RAM.
// One request in flight at a time. Loads read one word and format it;
// SW writes directly; SB/SH do a read-modify-write of the containing word.
// Errors (misalignment, out of range, illegal op) answer after one cycle
// without touching the RAM.
module mem_access_unit #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    // CPU request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt,
    // CPU response side
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    // RAM side
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_SB  = 4'd9;
    localparam logic [3:0] OP_SH  = 4'd10;

    // Highest legal byte address, widened so addr+3 cannot wrap.
    localparam logic [32:0] LAST_BYTE = 33'(MEM_BYTES - 1);

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rt_q, rt_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;

    // Opcode classification helpers
    function automatic logic op_is_legal(input logic [3:0] op);
        return (op <= OP_LWR) || (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

    function automatic logic op_is_rmw(input logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    // ------------------------------------------------------------------
    // Request error check, evaluated on the incoming (unlatched) request
    // ------------------------------------------------------------------
    logic        req_err;
    logic [32:0] req_top_byte;

    // Last byte touched by the aligned word containing req_addr.
    assign req_top_byte = {1'b0, req_addr[31:2], 2'b11};

    // Misalignment, range and opcode legality of the incoming request
    always_comb begin
        req_err = 1'b0;
        if (!op_is_legal(req_op)) begin
            req_err = 1'b1;
        end
        if (req_top_byte > LAST_BYTE) begin
            req_err = 1'b1;
        end
        case (req_op)
            OP_LW, OP_SW: begin
                if (req_addr[1:0] != 2'b00) begin
                    req_err = 1'b1;
                end
            end
            OP_LH, OP_LHU, OP_SH: begin
                if (req_addr[0] != 1'b0) begin
                    req_err = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Store lane selection and read-modify-write merge
    // ------------------------------------------------------------------
    logic [1:0]  lane;
    logic [3:0]  store_be;
    logic [31:0] store_lanes;
    logic [31:0] merged_word;

    assign lane = addr_q[1:0];

    // Byte enables and replicated store data for the latched store op
    always_comb begin
        store_be    = 4'b0000;
        store_lanes = wdata_q;
        case (op_q)
            OP_SB: begin
                store_be    = 4'b0001 << lane;
                store_lanes = {4{wdata_q[7:0]}};
            end
            OP_SH: begin
                store_be    = lane[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{wdata_q[15:0]}};
            end
            OP_SW: begin
                store_be    = 4'b1111;
                store_lanes = wdata_q;
            end
            default: begin
            end
        endcase
    end

    // Enabled lanes take the new data, the rest keep the word just read.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            assign merged_word[8*gi +: 8] = store_be[gi] ? store_lanes[8*gi +: 8]
                                                         : mem_q[8*gi +: 8];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load formatting
    // ------------------------------------------------------------------
    logic [4:0]  shift_lo;     // 8*b
    logic [4:0]  shift_hi;     // 8*(3-b)
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] lwl_word;
    logic [31:0] lwr_word;
    logic [31:0] load_word;

    assign shift_lo  = {lane, 3'b000};
    assign shift_hi  = {2'd3 - lane, 3'b000};
    assign lane_byte = mem_q[shift_lo +: 8];
    assign lane_half = lane[1] ? mem_q[31:16] : mem_q[15:0];

    // Unaligned-left/right loads keep the rt bytes not covered by memory.
    assign lwl_word = (mem_q << shift_hi) | (rt_q & ((32'd1 << shift_hi) - 32'd1));
    assign lwr_word = (mem_q >> shift_lo) | (rt_q & ~(32'hFFFF_FFFF >> shift_lo));

    // Select and extend the load result for the latched op
    always_comb begin
        load_word = 32'd0;
        case (op_q)
            OP_LW:   load_word = mem_q;
            OP_LB:   load_word = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_word = {24'd0, lane_byte};
            OP_LH:   load_word = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_word = {16'd0, lane_half};
            OP_LWL:  load_word = lwl_word;
            OP_LWR:  load_word = lwr_word;
            default: load_word = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // Next-state and next-register logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rt_d     = rt_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d     = req_op;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rt_d     = req_rt;
                    result_d = 32'd0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (req_op == OP_SW) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (op_is_rmw(op_q)) begin
                    // The merged word replaces the raw store data for the WR cycle.
                    wdata_d = merged_word;
                    state_d = WR;
                end else begin
                    result_d = load_word;
                    state_d  = RESP;
                end
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rt_q     <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rt_q     <= rt_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = resp_valid ? result_q : 32'd0;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wdata_q;
    // Gated by rst_n so an asserted reset kills a write already in WR.
    assign mem_we     = (state_q == WR) && rst_n;

endmodule
